// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-bank write-port arbiter.
package regfile_arb_pkg;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_DBG  = 2;

   localparam int REG_NUM_DEF    = 32;
   localparam int DATA_WIDTH_DEF = 64;
   localparam int ADDR_W_DEF     = $clog2(REG_NUM_DEF);

   typedef struct packed {
      logic [ADDR_W_DEF-1:0]     addr;
      logic [DATA_WIDTH_DEF-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: round-robin starting at ptr when RF_ARB_RR_EN is defined,
// otherwise a fixed-priority encoder where index 0 wins.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

`ifdef RF_ARB_RR_EN
   int               cand_i;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan N slots starting at ptr, wrapping modulo N; first valid slot wins.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      found  = 1'b0;
      cand_i = 0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand_i = int'(ptr) + k;
         if (cand_i >= N) cand_i = cand_i - N;
         cand = IDX_W'(cand_i);
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (en && req[k]) begin
            gnt    = '0;
            gnt[k] = 1'b1;
            idx    = IDX_W'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank write port among NUM_REQ writeback sources; one registered write per cycle, x0 suppressed.
// Build option RF_ARB_RR_EN selects round-robin arbitration; default is fixed priority (ALU > load > debug).
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int REG_NUM    = REG_NUM_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_W     = $clog2(REG_NUM),
   parameter int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [GID_W-1:0]              grant_id,
   output logic                          conflict
);

   // Handshake: a request i transfers at a rising edge when req_valid[i] && req_ready[i];
   // req_ready is a combinational one-hot grant, forced low during reset.
   logic [GID_W-1:0]      gnt_idx;
   logic [GID_W-1:0]      arb_ptr;
   logic                  accept;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0]     wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
   logic [GID_W-1:0]      grant_id_q, grant_id_d;
   logic                  conflict_q, conflict_d;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (GID_W)
   ) u_arb (
      .req (req_valid),
      .ptr (arb_ptr),
      .en  (!reset),
      .gnt (req_ready),
      .idx (gnt_idx)
   );

   assign accept = |req_ready;

`ifdef RF_ARB_RR_EN
   logic [GID_W-1:0] ptr_q, ptr_d;

   // Pointer moves past every accepted requester, including x0 writes.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + GID_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign arb_ptr = ptr_q;
`else
   assign arb_ptr = '0;
`endif

   always_comb begin
      sel_addr   = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      sel_data   = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      grant_id_d = grant_id_q;
      conflict_d = ($countones(req_valid) > 1);
      if (accept) begin
         grant_id_d = gnt_idx;
         if (sel_addr != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         grant_id_q <= '0;
         conflict_q <= 1'b0;
      end else begin
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         grant_id_q <= grant_id_d;
         conflict_q <= conflict_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign grant_id = grant_id_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: grant vector table plus hand sequences, registered outputs checked via a queue.
module tb_regfile_write_arbiter;
   import regfile_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_WIDTH_DEF;
   localparam int GW = 2;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [GW-1:0] gid;
      logic          conf;
   } out_t;
   localparam int OW = $bits(out_t);

   typedef struct packed {
      logic [N-1:0]    valid;
      logic [N*AW-1:0] addr;
      logic [N*DW-1:0] data;
      logic [N-1:0]    ready;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [GW-1:0]   grant_id;
   logic            conflict;

   logic [OW-1:0] exp_q[$];
   logic [DW-1:0] bank [REG_NUM_DEF];
   int            total = 0;
   int            bad   = 0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [GW-1:0] m_gid;

   regfile_write_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .conflict  (conflict)
   );

   always #5 clk = ~clk;

   // Bank model commits on the falling edge, x0 hardwired.
   always @(negedge clk) begin
      if (wr_en && wr_addr != '0) bank[wr_addr] <= wr_data;
   end

   task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // One clock: check grant at negedge, queue the expected registered outputs, compare after the edge.
   task automatic cycle(input logic [N-1:0] er);
      out_t          e;
      int            idx;
      logic [AW-1:0] a;
      logic [OW-1:0] got;
      e = '0;
      @(negedge clk);
      chk("req_ready", OW'(req_ready), OW'(er));
      if (reset) begin
         m_addr = '0;
         m_data = '0;
         m_gid  = '0;
      end else begin
         e.conf = ($countones(req_valid) > 1);
         idx = -1;
         for (int k = N - 1; k >= 0; k--) if (er[k]) idx = k;
         if (idx >= 0) begin
            a     = req_addr[idx*AW +: AW];
            m_gid = GW'(idx);
            if (a != '0) begin
               e.en   = 1'b1;
               m_addr = a;
               m_data = req_data[idx*DW +: DW];
            end
         end
      end
      e.addr = m_addr;
      e.data = m_data;
      e.gid  = m_gid;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = {wr_en, wr_addr, wr_data, grant_id, conflict};
      chk("outputs", got, exp_q.pop_front());
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      cycle('0);
      reset = 1'b0;
   endtask

   vec_t          vecs[8];
   logic [N-1:0]  seq[4];
   logic [DW-1:0] d0, d1, d2;
   int            vi;
   logic [AW-1:0] va;

   initial begin
      for (int i = 0; i < REG_NUM_DEF; i++) bank[i] = '0;
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      m_addr    = '0;
      m_data    = '0;
      m_gid     = '0;

      vecs[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 64'd0, 64'hDEAD_BEEF_0000_0001}, 3'b001};
      vecs[1] = '{3'b010, {5'd0, 5'd0, 5'd0}, {64'd0, 64'hFFFF, 64'd0}, 3'b010};
      vecs[2] = '{3'b100, {5'd31, 5'd0, 5'd0}, {{$urandom, $urandom}, 64'd0, 64'd0}, 3'b100};
      vecs[3] = '{3'b110, {5'd4, 5'd3, 5'd0}, {{$urandom, $urandom}, {$urandom, $urandom}, 64'd0}, 3'b010};
      vecs[4] = '{3'b111, {5'd9, 5'd8, 5'd6}, {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}}, 3'b001};
      vecs[5] = '{3'b101, {5'd12, 5'd0, 5'd0}, {{$urandom, $urandom}, 64'd0, 64'h55}, 3'b001};
      vecs[6] = '{3'b000, {5'd1, 5'd2, 5'd3}, {{$urandom, $urandom}, 64'd7, 64'd9}, 3'b000};
      vecs[7] = '{3'b011, {5'd0, 5'd17, 5'd18}, {64'd0, {$urandom, $urandom}, {$urandom, $urandom}}, 3'b001};

      // Requests during reset are not accepted; then idle.
      req_valid = 3'b111;
      cycle('0);
      cycle('0);
      reset     = 1'b0;
      req_valid = '0;
      for (int i = 0; i < 5; i++) cycle('0);

      // Single-cycle grant table, each from a fresh reset.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         req_valid = vecs[i].valid;
         req_addr  = vecs[i].addr;
         req_data  = vecs[i].data;
         cycle(vecs[i].ready);
         req_valid = '0;
         cycle('0);
         if (vecs[i].ready != '0) begin
            vi = -1;
            for (int k = N - 1; k >= 0; k--) if (vecs[i].ready[k]) vi = k;
            va = vecs[i].addr[vi*AW +: AW];
            if (va != '0) chk("bank_write", OW'(bank[va]), OW'(vecs[i].data[vi*DW +: DW]));
            else          chk("bank_x0", OW'(bank[0]), OW'(0));
         end
      end

      // All three valid, held until accepted.
      do_reset();
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      set_req(REQ_ALU, 1'b1, 5'd1, d0);
      set_req(REQ_LOAD, 1'b1, 5'd2, d1);
      set_req(REQ_DBG, 1'b1, 5'd3, d2);
      cycle(3'b001);
      req_valid[REQ_ALU] = 1'b0;
      cycle(3'b010);
      req_valid[REQ_LOAD] = 1'b0;
      cycle(3'b100);
      req_valid[REQ_DBG] = 1'b0;
      for (int i = 0; i < 3; i++) cycle('0);
      chk("bank_x1", OW'(bank[1]), OW'(d0));
      chk("bank_x2", OW'(bank[2]), OW'(d1));
      chk("bank_x3", OW'(bank[3]), OW'(d2));

      // Same-address collision: loser's data lands last.
      do_reset();
      set_req(REQ_ALU, 1'b1, 5'd7, 64'h11);
      set_req(REQ_LOAD, 1'b1, 5'd7, 64'h22);
      cycle(3'b001);
      req_valid[REQ_ALU] = 1'b0;
      cycle(3'b010);
      req_valid = '0;
      cycle('0);
      cycle('0);
      chk("bank_x7", OW'(bank[7]), OW'(64'h22));

      // Continuous requests from all three: rotation vs fixed priority.
`ifdef RF_ARB_RR_EN
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
`else
      seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001; seq[3] = 3'b001;
`endif
      do_reset();
      set_req(REQ_ALU, 1'b1, 5'd20, {$urandom, $urandom});
      set_req(REQ_LOAD, 1'b1, 5'd21, {$urandom, $urandom});
      set_req(REQ_DBG, 1'b1, 5'd22, {$urandom, $urandom});
      for (int i = 0; i < 4; i++) cycle(seq[i]);
      req_valid = '0;
      cycle('0);

      // An x0 accept from load also advances the round-robin pointer.
      do_reset();
      set_req(REQ_LOAD, 1'b1, 5'd0, 64'hFFFF);
      cycle(3'b010);
      req_valid[REQ_LOAD] = 1'b0;
      set_req(REQ_ALU, 1'b1, 5'd23, {$urandom, $urandom});
      set_req(REQ_DBG, 1'b1, 5'd24, {$urandom, $urandom});
`ifdef RF_ARB_RR_EN
      cycle(3'b100);
`else
      cycle(3'b001);
`endif
      req_valid = '0;
      cycle('0);

      // Reset the cycle after an accept: write dropped, pointer back at 0.
      do_reset();
      set_req(REQ_ALU, 1'b1, 5'd9, {$urandom, $urandom});
      cycle(3'b001);
      req_valid[REQ_ALU] = 1'b0;
      set_req(REQ_LOAD, 1'b1, 5'd10, {$urandom, $urandom});
      reset = 1'b1;
      cycle('0);
      reset = 1'b0;
      set_req(REQ_ALU, 1'b1, 5'd11, {$urandom, $urandom});
      cycle(3'b001);
      req_valid[REQ_ALU] = 1'b0;
      cycle(3'b010);
      req_valid = '0;
      cycle('0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
